// File: rtl/wb_pkg.sv
// Shared Wishbone initiator definitions:
// response status codes and initiator FSM state encoding.
package wb_pkg;

  localparam logic [1:0] WB_RSP_OK      = 2'b00;
  localparam logic [1:0] WB_RSP_ERR     = 2'b01;
  localparam logic [1:0] WB_RSP_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {
    WB_IDLE = 2'd0,
    WB_BUS  = 2'd1,
    WB_RESP = 2'd2
  } wb_state_e;

endpackage

// File: rtl/wb_timeout_ctr.sv
// Bus-cycle watchdog: counts enabled cycles since clear and flags the last
// allowed cycle. Ports: clk, rst, clr, en in; expire out. TIMEOUT=0 disables.
module wb_timeout_ctr #(
  parameter int TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LAST =
    (TIMEOUT == 0) ? '0 : W'(TIMEOUT - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Counter starts at 0 in the first bus cycle, so LAST marks the
  // TIMEOUT-th cycle of cyc_o.
  assign expire = (TIMEOUT != 0) && en && (cnt_q == LAST);

endmodule

// File: rtl/wb_master_cmd.sv
// Wishbone classic single-word initiator: command stream in, one bus cycle,
// response stream out. Ports: cmd_* (valid/ready), rsp_* (valid/ready), Wishbone.
module wb_master_cmd
  import wb_pkg::*;
#(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 32,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8,
  parameter int TIMEOUT      = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_data,
  input  logic                    cmd_we,
  input  logic [SELECT_WIDTH-1:0] cmd_sel,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic [1:0]              rsp_status,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ADDR_WIDTH-1:0]   adr_o,
  input  logic [DATA_WIDTH-1:0]   dat_i,
  output logic [DATA_WIDTH-1:0]   dat_o,
  output logic                    we_o,
  output logic [SELECT_WIDTH-1:0] sel_o,
  output logic                    stb_o,
  input  logic                    ack_i,
  input  logic                    err_i,
  output logic                    cyc_o
);

  wb_state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
  logic [DATA_WIDTH-1:0]   dat_q, dat_d;
  logic                    we_q, we_d;
  logic [SELECT_WIDTH-1:0] sel_q, sel_d;
  logic                    cyc_q, cyc_d;
  logic                    stb_q, stb_d;
  logic [DATA_WIDTH-1:0]   rdat_q, rdat_d;
  logic [1:0]              rst_q, rst_d;
  logic                    rvld_q, rvld_d;

  logic expire;

  wb_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .clr    (state_q == WB_IDLE),
    .en     (state_q == WB_BUS),
    .expire (expire)
  );

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    we_d    = we_q;
    sel_d   = sel_q;
    cyc_d   = cyc_q;
    stb_d   = stb_q;
    rdat_d  = rdat_q;
    rst_d   = rst_q;
    rvld_d  = rvld_q;
    unique case (state_q)
      WB_IDLE: begin
        if (cmd_valid) begin
          adr_d   = cmd_addr;
          dat_d   = cmd_data;
          we_d    = cmd_we;
          sel_d   = cmd_sel;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          state_d = WB_BUS;
        end
      end
      WB_BUS: begin
        // err has priority over ack; timeout only when neither arrives
        if (err_i || ack_i || expire) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          rvld_d  = 1'b1;
          state_d = WB_RESP;
          rdat_d  = '0;
          if (err_i) begin
            rst_d = WB_RSP_ERR;
          end else if (ack_i) begin
            rst_d = WB_RSP_OK;
            if (!we_q) rdat_d = dat_i;
          end else begin
            rst_d = WB_RSP_TIMEOUT;
          end
        end
      end
      WB_RESP: begin
        if (rsp_ready) begin
          rvld_d  = 1'b0;
          state_d = WB_IDLE;
        end
      end
      default: begin
        state_d = WB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WB_IDLE;
      adr_q   <= '0;
      dat_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      rdat_q  <= '0;
      rst_q   <= WB_RSP_OK;
      rvld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      rdat_q  <= rdat_d;
      rst_q   <= rst_d;
      rvld_q  <= rvld_d;
    end
  end

  assign cmd_ready  = (state_q == WB_IDLE);
  assign adr_o      = adr_q;
  assign dat_o      = dat_q;
  assign we_o       = we_q;
  assign sel_o      = sel_q;
  assign cyc_o      = cyc_q;
  assign stb_o      = stb_q;
  assign rsp_data   = rdat_q;
  assign rsp_status = rst_q;
  assign rsp_valid  = rvld_q;

endmodule

// File: doc/wb_master_cmd.md
Name: wb_master_cmd

Overview:
Wishbone classic initiator for single-word transactions. It converts a valid/ready command stream (address, data, write-enable, select) into one Wishbone cycle, then returns read data and a status on a valid/ready response stream. It sits between control logic (CPU bridge, DMA sequencer, test harness) and Wishbone responders such as the team's RAM and register blocks. A timeout protects against absent or hung responders.

Parameters:
ADDR_WIDTH, 16, address bus width in bits; byte address, passed through unchanged.
DATA_WIDTH, 32, data bus width in bits (8, 16, 32 or 64).
SELECT_WIDTH, DATA_WIDTH/8, byte-select width (1, 2, 4 or 8).
TIMEOUT, 256, cycles of cyc_o without ack_i/err_i before abort; 0 disables the timeout.

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  reset, asynchronous, active-high
cmd_addr  in  ADDR_WIDTH  transaction address
cmd_data  in  DATA_WIDTH  write data (ignored for reads)
cmd_we  in  1  1 = write, 0 = read
cmd_sel  in  SELECT_WIDTH  byte selects
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
rsp_data  out  DATA_WIDTH  read data; 0 for writes and errors
rsp_status  out  2  00 OK, 01 bus error, 10 timeout
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
adr_o  out  ADDR_WIDTH  ADR_O()
dat_i  in  DATA_WIDTH  DAT_I()
dat_o  out  DATA_WIDTH  DAT_O()
we_o  out  1  WE_O
sel_o  out  SELECT_WIDTH  SEL_O()
stb_o  out  1  STB_O
ack_i  in  1  ACK_I
err_i  in  1  ERR_I
cyc_o  out  1  CYC_O

Behaviour:
- FSM states: IDLE, BUS, RESP. Reset state is IDLE. All outputs are registered, except cmd_ready, which is decoded from the state.
- Reset values: all outputs 0; cmd_ready is 1 in IDLE. When rst is asserted mid-transaction, cyc_o and stb_o drop asynchronously and any pending response is discarded.
- IDLE: cmd_ready=1. On cmd_valid, latch cmd_* into adr_o, dat_o, we_o and sel_o. cyc_o and stb_o go to 1 on the same edge. Clear the timeout counter. Go to BUS.
- BUS: cyc_o=stb_o=1, and adr_o, dat_o, we_o and sel_o are held stable. The counter increments every cycle.
  - err_i=1: status 01, rsp_data 0.
  - else ack_i=1: status 00; rsp_data = dat_i if a read, 0 if a write.
  - else counter == TIMEOUT-1 with TIMEOUT != 0: status 10, rsp_data 0.
  - On any of these three exits, on that same edge: cyc_o=stb_o=0, rsp_valid=1, go to RESP.
  - ack_i and err_i in the same cycle: err wins.
- RESP: rsp_valid, rsp_data and rsp_status are held until rsp_ready. On the handshake edge: rsp_valid=0, go to IDLE. cmd_ready stays 0 during RESP (no command overlap).
- ack_i and err_i are ignored outside BUS. A late ack after a timeout has no effect.
- Latency against a responder that acks one cycle after seeing stb:
  - command accept edge -> cyc_o high for 2 cycles -> rsp_valid high.
  - Minimum 4 cycles per transaction with rsp_ready tied 1.
- Timeout counter width: $clog2(TIMEOUT+1), minimum 1 bit. TIMEOUT=1 aborts after one BUS cycle unless ack/err arrives in that cycle.
- No burst tags, no pipelined mode; the cycle is always Wishbone classic.

Decomposition:
- Shared package wb_pkg holds:
  - status constants WB_RSP_OK=2'b00, WB_RSP_ERR=2'b01, WB_RSP_TIMEOUT=2'b10;
  - FSM state encoding, reusable by future initiators.
- One natural sub-module: wb_timeout_ctr, holding the counter with clear/enable inputs and an expire output, parameterised by TIMEOUT. Everything else stays in wb_master_cmd.

Test Plan:
- Write with wb_ram attached (DATA_WIDTH 32): cmd addr 0x0010, data 0xDEADBEEF, we 1, sel 0xF -> cyc_o high exactly 2 cycles; rsp status 00, rsp_data 0; RAM word 4 = 0xDEADBEEF.
- Read back addr 0x0010 -> rsp_data 0xDEADBEEF, status 00. Then write 0x0000AB00 with sel 0x2, then read -> 0xDEADABEF.
- No responder (ack_i=err_i=0), TIMEOUT=16 -> cyc_o high exactly 16 cycles; rsp_status 10, rsp_data 0. A forced ack_i 3 cycles later is ignored and cmd_ready returns.
- Responder asserts ack_i and err_i together on a read -> status 01, rsp_data 0, cyc_o drops the same edge.
- Hold rsp_ready low for 5 cycles after a read -> rsp_valid, rsp_data and rsp_status stable for all 5 cycles; cmd_ready 0 throughout; one-cycle handshake, then IDLE.
- Assert rst in the first BUS cycle -> cyc_o and stb_o 0 immediately (before the next edge); rsp_valid 0; after release cmd_ready=1 and no response is emitted.
